// File: rtl/clmul_pkg.sv
// clmul_pkg: shared types and helpers for the digit-serial carry-less MAC.
//   state_t      - engine states IDLE, RUN, REDUCE, DONE
//   clmul_n      - number of RUN cycles (W / DIGIT)
//   clmul_cnt_w  - digit counter width, $clog2(N+1)
//   clmul_digit  - one digit step of the GF(2) shift-and-XOR multiply
// The digit helper works on fixed maximum-width vectors so that a single
// package serves every W; callers zero-extend operands and truncate results.
package clmul_pkg;

  localparam int MAX_W = 64;
  localparam int EXT_W = 2 * MAX_W - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int clmul_n(input int w, input int digit);
    return w / digit;
  endfunction

  function automatic int clmul_cnt_w(input int w, input int digit);
    return $clog2(w / digit + 1);
  endfunction

  // XOR a, shifted to each set multiplier bit position of this digit, into
  // the accumulator. bdigit carries only the bits of the current digit in
  // its low positions; higher bits must be zero.
  function automatic logic [EXT_W-1:0] clmul_digit(
    input logic [EXT_W-1:0] acc,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] bdigit,
    input int unsigned      shift
  );
    logic [EXT_W-1:0] r;
    logic [EXT_W-1:0] a_ext;
    r     = acc;
    a_ext = EXT_W'(a);
    for (int j = 0; j < MAX_W; j++) begin
      if (bdigit[j]) r = r ^ (a_ext << (shift + unsigned'(j)));
    end
    return r;
  endfunction

endpackage

// File: rtl/clmul_mac_seq_if.sv
// clmul_mac_seq_if: operand and result handshakes of the carry-less MAC.
//   in_valid/in_ready  - operand handshake (in_a, in_b, in_acc)
//   out_valid/out_ready - result handshake (out_data, 2W-1 bits)
// Modports: master drives operands and accepts results; slave is the engine.
interface clmul_mac_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_acc;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-2:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf2_reduce.sv
// gf2_reduce: purely combinational reduction of a 2W-1 bit GF(2) polynomial
// modulo POLY (W+1 bits, MSB set) by long division from bit 2W-2 down to W.
//   prod - carry-less product, 2W-1 bits
//   rem  - remainder, W bits
module gf2_reduce #(
  parameter int         W    = 8,
  parameter logic [W:0] POLY = (W+1)'(9'h11B)
) (
  input  logic [2*W-2:0] prod,
  output logic [W-1:0]   rem
);

  logic [2*W-2:0] work;

  // Clear the top set bit each step by XORing the aligned polynomial;
  // walking downwards guarantees earlier cancellations are never undone.
  always_comb begin
    work = prod;
    for (int i = 2*W-2; i >= W; i--) begin
      if (work[i]) work = work ^ ((2*W-1)'(POLY) << (i - W));
    end
    rem = work[W-1:0];
  end

endmodule

// File: rtl/clmul_mac_seq.sv
// clmul_mac_seq: digit-serial carry-less (GF(2)) multiply-accumulate engine.
// Computes P = A*B over GF(2)[x], optionally XORed with the previously
// delivered result, consuming DIGIT multiplier bits per cycle.
//   clk, rst - clock and synchronous active-high reset
//   bus      - clmul_mac_seq_if slave: operand and result handshakes
//   busy     - high while in RUN or REDUCE
// Optional build macro CLMUL_REDUCE_EN adds a one-cycle REDUCE state that
// folds the product modulo POLY; results then live in out_data[W-1:0].
module clmul_mac_seq
  import clmul_pkg::*;
#(
  parameter int         W     = 8,
  parameter int         DIGIT = 2,
  parameter logic [W:0] POLY  = (W+1)'(9'h11B)
) (
  input  logic             clk,
  input  logic             rst,
  clmul_mac_seq_if.slave   bus,
  output logic             busy
);

  localparam int N     = clmul_n(W, DIGIT);
  localparam int CNT_W = clmul_cnt_w(W, DIGIT);
  localparam int PW    = 2 * W - 1;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  // Elaboration-time sanity checks on the configuration.
  if (W < 2 || W > MAX_W) begin : g_bad_w
    $error("clmul_mac_seq: W out of range");
  end
  if (DIGIT < 1 || (W % DIGIT) != 0) begin : g_bad_digit
    $error("clmul_mac_seq: DIGIT must divide W");
  end
  if (POLY[W] != 1'b1) begin : g_bad_poly
    $error("clmul_mac_seq: POLY MSB must be set");
  end

  state_t             state;
  state_t             state_next;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      acc_step;
  logic [PW-1:0]      last_result;
  logic [PW-1:0]      out_data_reg;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       b_digit;
  int unsigned        shift_amt;
  logic               last_digit;

`ifdef CLMUL_REDUCE_EN
  logic [W-1:0] acc_reduced;

  gf2_reduce #(
    .W    (W),
    .POLY (POLY)
  ) u_reduce (
    .prod (acc),
    .rem  (acc_reduced)
  );
`endif

  // Select the current multiplier digit and compute the accumulator value
  // after this digit's partial products are folded in.
  always_comb begin
    shift_amt = unsigned'(int'(cnt) * DIGIT);
    b_digit   = '0;
    for (int j = 0; j < DIGIT; j++) begin
      b_digit[j] = b_reg[IDX_W'(int'(cnt) * DIGIT + j)];
    end
    acc_step   = PW'(clmul_digit(EXT_W'(acc), MAX_W'(a_reg), MAX_W'(b_digit), shift_amt));
    last_digit = (cnt == CNT_W'(N - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. Latency is fixed at N RUN cycles regardless of data.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
`ifdef CLMUL_REDUCE_EN
      RUN:     if (last_digit) state_next = REDUCE;
`else
      RUN:     if (last_digit) state_next = DONE;
`endif
      REDUCE:  state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state, so out_valid cannot
  // drop before the consumer takes the result and in_ready returns only
  // the cycle after that.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state == RUN) || (state == REDUCE);
  end

  assign bus.out_data = out_data_reg;

  // Datapath: capture operands, step the accumulator, and publish the final
  // value into both the output register and the last-result register as
  // the engine enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      acc          <= '0;
      cnt          <= '0;
      last_result  <= '0;
      out_data_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            acc   <= bus.in_acc ? last_result : '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
`ifndef CLMUL_REDUCE_EN
          if (last_digit) begin
            out_data_reg <= acc_step;
            last_result  <= acc_step;
          end
`endif
        end
`ifdef CLMUL_REDUCE_EN
        REDUCE: begin
          acc          <= PW'(acc_reduced);
          out_data_reg <= PW'(acc_reduced);
          last_result  <= PW'(acc_reduced);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_mac_seq.sv
// tb_clmul_mac_seq: self-checking bench for clmul_mac_seq (W=8, DIGIT=2).
// Expected results come from a bit-level carry-less reference model or from
// hand-derived constants, queued when operands are accepted and popped when
// the engine delivers a result. Honours CLMUL_REDUCE_EN.
`timescale 1ns/1ps
module tb_clmul_mac_seq;

  localparam int W      = 8;
  localparam int DIGIT  = 2;
  localparam int N      = W / DIGIT;
  localparam int PW     = 2 * W - 1;
  localparam int BUDGET = 100;
`ifdef CLMUL_REDUCE_EN
  localparam int         LAT       = N + 1;
  localparam logic [W:0] REF_POLY  = 9'h11B;
  localparam logic       USE_FIXED = 1'b0;
`else
  localparam int         LAT       = N;
  localparam logic       USE_FIXED = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] model_last;

  clmul_mac_seq_if #(.W(W)) bus();

  clmul_mac_seq #(
    .W     (W),
    .DIGIT (DIGIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Bit-level reference: sum of a[i]&b[k] at x^(i+k), optional reduction,
  // then optional XOR with the previously delivered result.
  function automatic logic [PW-1:0] ref_mac(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic acc, input logic [PW-1:0] last);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      for (int k = 0; k < W; k++)
        if (a[i] && b[k]) p[i+k] = ~p[i+k];
`ifdef CLMUL_REDUCE_EN
    for (int d = PW-1; d >= W; d--)
      if (p[d]) p = p ^ (PW'(REF_POLY) << (d - W));
`endif
    return acc ? (p ^ last) : p;
  endfunction

  // Offer one operand set and wait (bounded) for acceptance. On return the
  // time is just after the accepting edge and the expectation is queued.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                      input logic use_fixed, input logic [PW-1:0] fixed);
    int t;
    logic [PW-1:0] e;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = acc;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      e = use_fixed ? fixed : ref_mac(a, b, acc, model_last);
      model_last = e;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for a result and take it, optionally with random
  // backpressure; returns the observed data.
  task automatic collect(input logic random_ready, output logic [PW-1:0] got, output logic ok);
    int t;
    ok  = 1'b0;
    got = '0;
    t   = 0;
    while (!ok && t < BUDGET) begin
      @(negedge clk);
      t++;
      bus.out_ready = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got = bus.out_data;
        ok  = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      bus.out_ready = 1'b0;
      $display("[TB] FAIL collect_timeout: out_valid=%0b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_product;
    int k;
    logic seen, ok;
    logic [PW-1:0] got, e;
    $display("[TB] basic product and latency");
    send(8'h03, 8'h03, 1'b0, USE_FIXED, 15'h0005);
    k = 0;
    seen = 1'b0;
    while (!seen && k <= LAT + 3) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL run_flags: edge %0d in_ready=%0b busy=%0b want 0/1", k, bus.in_ready, busy);
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    checks++;
    if (!seen || k != LAT) begin
      errors++;
      $display("[TB] FAIL latency: got %0d edges (seen=%0b) want %0d", k, seen, LAT);
    end
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL basic_data: got %h want %h", got, e); end
    end
  endtask

  task automatic test_accumulate;
    logic ok;
    logic [PW-1:0] got, e;
    $display("[TB] full product then accumulate");
    send(8'hFF, 8'hFF, 1'b0, USE_FIXED, 15'h5555);
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL ff_data: got %h want %h", got, e); end
    end
    send(8'h01, 8'h05, 1'b1, USE_FIXED, 15'h5550);
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL acc_data: got %h want %h", got, e); end
    end
  endtask

  task automatic test_backpressure;
    int t;
    logic ok;
    logic [PW-1:0] got, e;
    $display("[TB] backpressure");
    send(8'h12, 8'h34, 1'b0, 1'b0, '0);
    t = 0;
    while (!bus.out_valid && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    e = exp_q[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.in_a     = 8'hFF;
        bus.in_b     = 8'hFF;
        bus.in_acc   = 1'b1;
        bus.in_valid = 1'b1;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold: cycle %0d valid=%0b data=%h in_ready=%0b want 1/%h/0", c, bus.out_valid, bus.out_data, bus.in_ready, e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL bp_data: got %h want %h", got, e); end
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release: in_ready=%0b out_valid=%0b busy=%0b want 1/0/0", bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    logic ok;
    logic [PW-1:0] got, e;
    $display("[TB] reset during RUN");
    send(8'hA5, 8'h3C, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: in_ready=%0b out_valid=%0b data=%h busy=%0b want 1/0/0/0", bus.in_ready, bus.out_valid, bus.out_data, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_last = '0;
    send(8'h01, 8'h01, 1'b1, 1'b1, 15'h0001);
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL post_reset_data: got %h want %h", got, e); end
    end
  endtask

`ifdef CLMUL_REDUCE_EN
  task automatic test_reduce;
    logic ok;
    logic [PW-1:0] got, e;
    $display("[TB] field reduction");
    send(8'h53, 8'hCA, 1'b0, 1'b1, 15'h0001);
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL reduce_inv: got %h want %h", got, e); end
    end
    send(8'h02, 8'h80, 1'b0, 1'b1, 15'h001B);
    collect(1'b0, got, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL reduce_wrap: got %h want %h", got, e); end
    end
  endtask
`endif

  task automatic test_random;
    logic ok;
    logic [PW-1:0] got, e;
    $display("[TB] random transactions");
    for (int n = 0; n < 500; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
      collect(1'b1, got, ok);
      if (ok) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra: got %h with no pending expectation", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("[TB] FAIL rand_data: txn %0d got %h want %h", n, got, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_dropped: %0d results pending want 0", exp_q.size());
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    model_last    = '0;
    test_reset();
    test_basic_product();
    test_accumulate();
    test_backpressure();
    test_reset_mid_run();
`ifdef CLMUL_REDUCE_EN
    test_reduce();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
